// File: rtl/avalon_pio_edge_capture_in_pkg.sv
// Shared definitions for the edge-capturing input PIO.
//   - Register word addresses on the Avalon-MM slave port.
//   - Encodings for the per-bit edge selection parameter.
package avalon_pio_edge_capture_in_pkg;

    // Register word addresses
    localparam logic [1:0] ADDR_DATA    = 2'd0;  // RO: synchronised input level
    localparam logic [1:0] ADDR_DIR     = 2'd1;  // reserved, reads 0
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;  // RW: interrupt mask
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;  // write-1-to-clear capture

    // Edge selection encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_pio_edge_capture_in_edge_detect.sv
// pio_sync_edge_detect: multi-flop synchroniser for an asynchronous input
// bus, followed by a one-cycle-delayed copy used for per-bit edge detection.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   in_port       : asynchronous external inputs
//   sync_q        : last synchroniser stage (clean level)
//   edge_hit      : one-cycle pulse per bit for the selected edge kind
module pio_sync_edge_detect
    import avalon_pio_edge_capture_in_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] edge_hit
);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_q <= sync_q;
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];
    assign rise   = sync_q & ~prev_q;
    assign fall   = ~sync_q & prev_q;

    // Edge kind is fixed at elaboration; unknown encodings fall back to rising.
    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_hit = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_hit = rise | fall;
        end else begin : g_rise
            assign edge_hit = rise;
        end
    endgenerate

endmodule

// File: rtl/avalon_pio_edge_capture_in.sv
// avalon_pio_edge_capture_in: Avalon-MM slave input PIO with edge capture
// and a maskable level interrupt (KEY / SW inputs).
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   address, chipselect   : word address and slave select
//   read_n, write_n       : active-low read / write strobes
//   writedata             : 32-bit write data
//   in_port               : asynchronous external inputs
//   readdata              : registered read data (1-cycle latency)
//   irq                   : active-high level interrupt
//
// Bus handshake: the slave has no waitrequest. A write takes effect on the
// clk edge where chipselect=1 and write_n=0. A read is accepted on the clk
// edge where chipselect=1 and read_n=0, and readdata is valid from that edge
// onward; readdata holds its value when no read is in progress. Reads have
// no side effects.
module avalon_pio_edge_capture_in
    import avalon_pio_edge_capture_in_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int SYNC_STAGES = 2,
    parameter int IRQ_EN      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_mux;
    logic             wr_cycle;
    logic             rd_cycle;
    logic             wr_mask;
    logic             wr_cap;
    logic             unused_wdata;

    pio_sync_edge_detect #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .sync_q   (sync_q),
        .edge_hit (edge_hit)
    );

    assign wr_cycle = chipselect & ~write_n;
    assign rd_cycle = chipselect & ~read_n;
    assign wr_mask  = wr_cycle && (address == ADDR_IRQMASK);
    assign wr_cap   = wr_cycle && (address == ADDR_EDGECAP);
    assign cap_clr  = wr_cap ? writedata[WIDTH-1:0] : '0;

    // Bits of writedata above WIDTH have no destination.
    assign unused_wdata = ^writedata;

    // Without interrupt support the mask is not stored at all.
    generate
        if (IRQ_EN != 0) begin : g_irq
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mask_q <= '0;
                end else if (wr_mask) begin
                    mask_q <= writedata[WIDTH-1:0];
                end
            end
            assign irq = |(cap_q & mask_q);
        end else begin : g_no_irq
            assign mask_q = '0;
            assign irq    = 1'b0;
        end
    endgenerate

    // A new edge is OR-ed in after the clear, so a set in the same cycle as
    // a write-1-to-clear of that bit wins and no edge is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= '0;
        end else begin
            cap_q <= edge_hit | (cap_q & ~cap_clr);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_q;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = cap_q;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_cycle) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_avalon_pio_edge_capture_in.sv
// Bench for avalon_pio_edge_capture_in: three instances share the bus and
// inputs (rising edge with irq, falling edge with irq, any edge without irq).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_avalon_pio_edge_capture_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd_rise, rd_fall, rd_any;
  logic        irq_rise, irq_fall, irq_any;

  int tests_run;
  int tests_failed;

  logic [32:0] exp_q[$];

  typedef struct {
    logic [3:0]  inp;
    logic        cs;
    logic        rdn;
    logic        wrn;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  avalon_pio_edge_capture_in #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2), .IRQ_EN(1)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_rise), .irq(irq_rise)
  );

  avalon_pio_edge_capture_in #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(2), .IRQ_EN(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_fall), .irq(irq_fall)
  );

  avalon_pio_edge_capture_in #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2), .IRQ_EN(0)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_any), .irq(irq_any)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic bus_idle();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
  endtask

  task automatic bus_cycle(input logic cs, input logic rdn, input logic wrn,
                           input logic [1:0] a, input logic [31:0] wd);
    chipselect = cs;
    read_n     = rdn;
    write_n    = wrn;
    address    = a;
    writedata  = wd;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic do_read(input logic [1:0] a);
    bus_cycle(1'b1, 1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] wd);
    bus_cycle(1'b1, 1'b1, 1'b0, a, wd);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic void add_vec(input logic [3:0] inp, input logic cs, input logic rdn,
                                  input logic wrn, input logic [1:0] a, input logic [31:0] wd,
                                  input logic [31:0] erd, input logic eirq);
    vec_t v;
    v.inp = inp; v.cs = cs; v.rdn = rdn; v.wrn = wrn; v.addr = a;
    v.wdata = wd; v.exp_rd = erd; v.exp_irq = eirq;
    vecs.push_back(v);
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    in_port      = 4'h0;
    bus_idle();

    // Per-cycle vectors for the rising-edge instance: {in_port, cs, read_n,
    // write_n, address, writedata} -> {readdata, irq} after that clk edge.
    // Level readback of 1010 held for several cycles
    add_vec(4'hA, 0, 1, 1, 2'd0, 32'h0, 32'h0, 0);
    add_vec(4'hA, 0, 1, 1, 2'd0, 32'h0, 32'h0, 0);
    add_vec(4'hA, 0, 1, 1, 2'd0, 32'h0, 32'h0, 0);
    add_vec(4'hA, 0, 1, 1, 2'd0, 32'h0, 32'h0, 0);
    add_vec(4'hA, 1, 0, 1, 2'd0, 32'h0, 32'hA, 0);
    // Clear the captures from the initial rise, then unmask bit0
    add_vec(4'hA, 1, 1, 0, 2'd3, 32'hF, 32'hA, 0);
    add_vec(4'hA, 1, 0, 1, 2'd3, 32'h0, 32'h0, 0);
    add_vec(4'hA, 1, 1, 0, 2'd2, 32'h1, 32'h0, 0);
    add_vec(4'hA, 1, 0, 1, 2'd2, 32'h0, 32'h1, 0);
    // bit0 rises: capture and irq on the third edge after the change
    add_vec(4'hB, 0, 1, 1, 2'd0, 32'h0, 32'h1, 0);
    add_vec(4'hB, 0, 1, 1, 2'd0, 32'h0, 32'h1, 0);
    add_vec(4'hB, 0, 1, 1, 2'd0, 32'h0, 32'h1, 1);
    add_vec(4'hB, 1, 0, 1, 2'd3, 32'h0, 32'h1, 1);
    add_vec(4'hB, 1, 1, 0, 2'd3, 32'h1, 32'h1, 0);
    add_vec(4'hB, 1, 0, 1, 2'd3, 32'h0, 32'h0, 0);
    // bit2 rises in the same cycle as its write-1-to-clear; then write 0
    add_vec(4'hF, 0, 1, 1, 2'd0, 32'h0, 32'h0, 0);
    add_vec(4'hF, 0, 1, 1, 2'd0, 32'h0, 32'h0, 0);
    add_vec(4'hF, 1, 1, 0, 2'd3, 32'h4, 32'h0, 0);
    add_vec(4'hF, 1, 1, 0, 2'd3, 32'h0, 32'h0, 0);
    add_vec(4'hF, 1, 0, 1, 2'd3, 32'h0, 32'h4, 0);
    // Masked capture on bit3, then late unmask raises irq
    add_vec(4'h7, 1, 1, 0, 2'd3, 32'h4, 32'h4, 0);
    add_vec(4'h7, 1, 1, 0, 2'd2, 32'h0, 32'h4, 0);
    add_vec(4'hF, 0, 1, 1, 2'd0, 32'h0, 32'h4, 0);
    add_vec(4'hF, 0, 1, 1, 2'd0, 32'h0, 32'h4, 0);
    add_vec(4'hF, 1, 0, 1, 2'd3, 32'h0, 32'h0, 0);
    add_vec(4'hF, 1, 0, 1, 2'd3, 32'h0, 32'h8, 0);
    add_vec(4'hF, 1, 1, 0, 2'd2, 32'h8, 32'h8, 1);
    add_vec(4'hF, 1, 0, 1, 2'd2, 32'h0, 32'h8, 1);
    // DIR reads 0; writes to DATA are ignored
    add_vec(4'hF, 1, 0, 1, 2'd1, 32'h0, 32'h0, 1);
    add_vec(4'hF, 1, 1, 0, 2'd0, 32'hFFFFFFFF, 32'h0, 1);
    add_vec(4'hF, 1, 0, 1, 2'd0, 32'h0, 32'hF, 1);
    // Out-of-range writedata bits are dropped
    add_vec(4'hF, 1, 1, 0, 2'd2, 32'hFFFFFFF8, 32'hF, 1);
    add_vec(4'hF, 1, 0, 1, 2'd2, 32'h0, 32'h8, 1);
    add_vec(4'hF, 1, 1, 0, 2'd3, 32'hFFFFFFF8, 32'h8, 0);
    add_vec(4'hF, 1, 0, 1, 2'd3, 32'h0, 32'h0, 0);
    // read_n low without chipselect: readdata holds
    add_vec(4'hF, 0, 0, 1, 2'd0, 32'h0, 32'h0, 0);

    // reset state
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("reset_readdata_rise", rd_rise, 32'h0);
    check("reset_irq_rise", {31'd0, irq_rise}, 32'h0);
    check("reset_readdata_any", rd_any, 32'h0);

    // table-driven section
    for (int i = 0; i < vecs.size(); i++) begin
      logic [32:0] exp;
      in_port    = vecs[i].inp;
      chipselect = vecs[i].cs;
      read_n     = vecs[i].rdn;
      write_n    = vecs[i].wrn;
      address    = vecs[i].addr;
      writedata  = vecs[i].wdata;
      exp_q.push_back({vecs[i].exp_irq, vecs[i].exp_rd});
      @(negedge clk);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d_readdata", i), rd_rise, exp[31:0]);
      check($sformatf("vec%0d_irq", i), {31'd0, irq_rise}, {31'd0, exp[32]});
    end
    bus_idle();

    // bit1 pulse 0->1->0, each level 3 clk, on falling and any-edge builds
    in_port = 4'h0;
    apply_reset();
    in_port = 4'h2;
    idle_cycles(3);
    in_port = 4'h0;
    do_read(2'd3);
    check("pulse_mid_fall_cap", rd_fall, 32'h0);
    check("pulse_mid_any_cap", rd_any, 32'h2);
    idle_cycles(4);
    do_read(2'd3);
    check("pulse_end_fall_cap", rd_fall, 32'h2);
    check("pulse_end_any_cap", rd_any, 32'h2);
    check("pulse_end_rise_cap", rd_rise, 32'h2);
    check("pulse_irq_any_tied", {31'd0, irq_any}, 32'h0);
    do_write(2'd3, 32'h2);
    do_read(2'd3);
    check("pulse_clr_any_cap", rd_any, 32'h0);
    check("pulse_clr_fall_cap", rd_fall, 32'h0);

    // Asynchronous reset with all captures pending and irq high
    in_port = 4'hF;
    idle_cycles(3);
    do_write(2'd2, 32'hF);
    do_read(2'd3);
    check("pre_rst_cap", rd_rise, 32'hF);
    check("pre_rst_irq", {31'd0, irq_rise}, 32'h1);
    check("no_irq_build_irq", {31'd0, irq_any}, 32'h0);
    do_read(2'd2);
    check("pre_rst_mask", rd_rise, 32'hF);
    check("no_irq_build_mask", rd_any, 32'h0);
    in_port = 4'h0;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_irq", {31'd0, irq_rise}, 32'h0);
    check("async_rst_readdata", rd_rise, 32'h0);
    check("async_rst_readdata_any", rd_any, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    do_read(2'd2);
    check("post_rst_mask", rd_rise, 32'h0);
    for (int i = 0; i < 10; i++) begin
      do_read(2'd3);
      check($sformatf("post_rst_cap_rise%0d", i), rd_rise, 32'h0);
      check($sformatf("post_rst_cap_any%0d", i), rd_any, 32'h0);
      check($sformatf("post_rst_irq%0d", i), {31'd0, irq_rise}, 32'h0);
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
